// File: rtl/spram_pkg.sv
// spram_pkg: shared types and helpers for the byte-enable single-port RAM.
//   rdw_mode_e   : output behaviour when a write is accepted
//   fill_state_e : post-reset zero-fill sequencer states
//   even_parity  : even-parity bit of a zero-extended byte (zero-extension keeps parity)
// Optional feature macro used by the RAM: SPRAM_PARITY_EN.
package spram_pkg;

  typedef enum logic [1:0] {
    NO_CHG   = 2'd0,
    WR_FIRST = 2'd1,
    RD_FIRST = 2'd2
  } rdw_mode_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fill_state_e;

  localparam int unsigned PAR_W = 64;

  // Parity bit that makes byte plus bit hold an even number of ones.
  function automatic logic even_parity(input logic [PAR_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/spram_rd_pipe.sv
// spram_rd_pipe: READ_LATENCY-deep (1 or 2) output register pipeline.
//   clk, rst_n  : clock, synchronous active-low reset (flushes all stages)
//   valid_i     : a result is produced this cycle
//   data_i      : result word, captured only with valid_i
//   par_err_i   : parity error of the result, qualified by valid_i
//   valid_o     : one-cycle strobe, READ_LATENCY cycles after valid_i
//   data_o      : result word; changes only together with valid_o
//   par_err_o   : parity error aligned with valid_o
module spram_rd_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_err_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  par_err_o
);

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_err_q;

  // First stage: data holds its value between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= valid_i;
      s1_err_q   <= valid_i & par_err_i;
      if (valid_i) s1_data_q <= data_i;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic                  s2_err_q;

    // Second stage: output register, loads only with a valid result.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
        s2_err_q   <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_valid_q & s1_err_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign valid_o   = s2_valid_q;
    assign data_o    = s2_data_q;
    assign par_err_o = s2_err_q;
  end else begin : g_lat1
    assign valid_o   = s1_valid_q;
    assign data_o    = s1_data_q;
    assign par_err_o = s1_err_q;
  end

endmodule

// File: rtl/spram_be_ctrl.sv
// spram_be_ctrl: single-port RAM with byte write enables, selectable read-during-write
// output, 1/2-cycle read latency with valid strobe and a post-reset zero-fill sequencer.
//   clk, rst_n     : clock, synchronous active-low reset
//   en_i, we_i     : request strobe (taken only while ready_o=1), 1=write 0=read
//   be_i           : byte write enables (writes only)
//   addr_i, di_i   : word address, write data
//   ready_o        : high once the zero-fill has covered every word
//   dout_o         : result word, holds between strobes
//   dout_valid_o   : one-cycle strobe qualifying dout_o
//   par_err_o      : byte parity mismatch on the strobed word
// Optional feature: define SPRAM_PARITY_EN to store one even-parity bit per byte;
// otherwise par_err_o is tied low.
module spram_be_ctrl
  import spram_pkg::*;
#(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter rdw_mode_e   RDW_MODE     = NO_CHG,
  parameter int unsigned ADDR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [NUM_BYTES-1:0]  be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] di_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  output logic                  par_err_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_ptr_q, fill_ptr_d;
  logic                  ready_q, ready_d;
  logic                  fill_we_c;

  logic                  req_c, in_range_c, wr_c;
  logic [DATA_WIDTH-1:0] rd_word_c, merged_c;
  logic                  pipe_valid_c, pipe_err_c;
  logic [DATA_WIDTH-1:0] pipe_data_c;

  // Fill FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      fill_ptr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
      ready_q    <= ready_d;
    end
  end

  // Fill FSM next state: one zero word per cycle, then RUN.
  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    fill_we_c  = 1'b0;
    unique case (state_q)
      INIT: begin
        fill_we_c = 1'b1;
        if (fill_ptr_q == LAST_ADDR) state_d = RUN;
        else                         fill_ptr_d = fill_ptr_q + ADDR_WIDTH'(1);
      end
      RUN: ;
    endcase
    ready_d = (state_d == RUN);
  end

  assign req_c      = en_i && ready_q && rst_n;
  assign in_range_c = (32'(addr_i) < DEPTH);
  assign wr_c       = req_c && we_i && in_range_c;
  assign rd_word_c  = in_range_c ? mem_q[addr_i] : '0;

  // Byte merge of the write data over the current word.
  always_comb begin
    merged_c = rd_word_c;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (be_i[i]) merged_c[i*BYTE_WIDTH +: BYTE_WIDTH] = di_i[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Result selection; out-of-range requests return zero.
  always_comb begin
    pipe_valid_c = 1'b0;
    pipe_data_c  = rd_word_c;
    if (req_c) begin
      if (!we_i) begin
        pipe_valid_c = 1'b1;
      end else if (RDW_MODE == WR_FIRST) begin
        pipe_valid_c = 1'b1;
        pipe_data_c  = in_range_c ? merged_c : '0;
      end else if (RDW_MODE == RD_FIRST) begin
        pipe_valid_c = 1'b1;
      end
    end
  end

  // Storage: zero-fill has priority, requests are blocked until ready anyway.
  always_ff @(posedge clk) begin
    if (rst_n && fill_we_c) mem_q[fill_ptr_q] <= '0;
    else if (wr_c)          mem_q[addr_i]     <= merged_c;
  end

`ifdef SPRAM_PARITY_EN
  logic [NUM_BYTES-1:0]  par_mem_q [DEPTH];
  logic [NUM_BYTES-1:0]  rd_par_c, merged_par_c, chk_par_c;
  logic [DATA_WIDTH-1:0] chk_word_c;

  // Parity of the word being returned: merged view on WR_FIRST writes.
  always_comb begin
    rd_par_c     = in_range_c ? par_mem_q[addr_i] : '0;
    merged_par_c = rd_par_c;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (be_i[i]) merged_par_c[i] = even_parity(PAR_W'(di_i[i*BYTE_WIDTH +: BYTE_WIDTH]));
    end
    if (we_i && (RDW_MODE == WR_FIRST)) begin
      chk_word_c = merged_c;
      chk_par_c  = merged_par_c;
    end else begin
      chk_word_c = rd_word_c;
      chk_par_c  = rd_par_c;
    end
    pipe_err_c = 1'b0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (even_parity(PAR_W'(chk_word_c[i*BYTE_WIDTH +: BYTE_WIDTH])) != chk_par_c[i]) begin
        pipe_err_c = 1'b1;
      end
    end
    if (!in_range_c) pipe_err_c = 1'b0;
  end

  // Parity storage follows the data array write-for-write.
  always_ff @(posedge clk) begin
    if (rst_n && fill_we_c) par_mem_q[fill_ptr_q] <= '0;
    else if (wr_c)          par_mem_q[addr_i]     <= merged_par_c;
  end
`else
  assign pipe_err_c = 1'b0;
`endif

  spram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (pipe_valid_c),
    .data_i   (pipe_data_c),
    .par_err_i(pipe_err_c),
    .valid_o  (dout_valid_o),
    .data_o   (dout_o),
    .par_err_o(par_err_o)
  );

  assign ready_o = ready_q;

endmodule

// File: tb/tb_spram_be_ctrl.sv
// tb_spram_be_ctrl: three RAM configurations driven by shared stimulus and checked
// every cycle against a word-level reference model (array + expected-result queue).
//   u0: DEPTH 32, latency 1, NO_CHG
//   u1: DEPTH 32, latency 2, WR_FIRST
//   u2: DEPTH 20, latency 1, RD_FIRST (addresses 20..31 are out of range)
module tb_spram_be_ctrl;
  import spram_pkg::*;

  localparam int NDUT = 3;
`ifdef SPRAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, en, we;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] di;
  logic [NDUT-1:0] rdy, dv, pe;
  logic [NDUT-1:0][31:0] dout;

  always #5 clk = ~clk;

  spram_be_ctrl #(.DEPTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(NO_CHG)) u0 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr), .di_i(di),
    .ready_o(rdy[0]), .dout_o(dout[0]), .dout_valid_o(dv[0]), .par_err_o(pe[0]));
  spram_be_ctrl #(.DEPTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(2), .RDW_MODE(WR_FIRST)) u1 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr), .di_i(di),
    .ready_o(rdy[1]), .dout_o(dout[1]), .dout_valid_o(dv[1]), .par_err_o(pe[1]));
  spram_be_ctrl #(.DEPTH(20), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(RD_FIRST)) u2 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr), .di_i(di),
    .ready_o(rdy[2]), .dout_o(dout[2]), .dout_valid_o(dv[2]), .par_err_o(pe[2]));

  // Reference model state.
  typedef struct {
    int          k;
    int          due;
    logic [31:0] d;
    logic        pe;
  } exp_t;

  int          dep      [NDUT];
  int          lat      [NDUT];
  rdw_mode_e   mode     [NDUT];
  logic [31:0] mm       [NDUT][32];
  logic [3:0]  bad      [NDUT][32];
  int          fill_cnt [NDUT];
  logic [31:0] last_d   [NDUT];
  exp_t        expq [$];
  int          cyc;
  int          errors;
  int          checks;

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] d, input logic p);
    exp_t e;
    e.k   = k;
    e.due = cyc + lat[k];
    e.d   = d;
    e.pe  = PAR_ON && p;
    expq.push_back(e);
  endtask

  task automatic accept(input int k);
    logic        inr;
    logic [31:0] old, mrg;
    logic [3:0]  obad, nbad;
    inr  = int'(addr) < dep[k];
    old  = inr ? mm[k][addr] : 32'h0;
    obad = inr ? bad[k][addr] : 4'h0;
    mrg  = old;
    for (int i = 0; i < 4; i++) if (be[i]) mrg[i*8 +: 8] = di[i*8 +: 8];
    nbad = obad & ~be;
    if (!we) begin
      push(k, old, |obad);
    end else begin
      if (mode[k] == WR_FIRST)      push(k, inr ? mrg : 32'h0, inr && (|nbad));
      else if (mode[k] == RD_FIRST) push(k, old, |obad);
      if (inr) begin
        mm[k][addr]  = mrg;
        bad[k][addr] = nbad;
      end
    end
  endtask

  // What the coming clock edge does to the model.
  task automatic model_edge();
    if (!rst_n) begin
      expq.delete();
      for (int k = 0; k < NDUT; k++) begin
        fill_cnt[k] = 0;
        last_d[k]   = 32'h0;
        for (int a = 0; a < 32; a++) begin
          mm[k][a]  = 32'h0;
          bad[k][a] = 4'h0;
        end
      end
      return;
    end
    for (int k = 0; k < NDUT; k++) begin
      if (en && fill_cnt[k] >= dep[k]) accept(k);
      if (fill_cnt[k] < dep[k]) fill_cnt[k]++;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NDUT; k++) begin
      logic        exp_v, exp_pe;
      logic [31:0] exp_d;
      int          idx;
      exp_v  = 1'b0;
      exp_pe = 1'b0;
      exp_d  = last_d[k];
      idx    = -1;
      for (int i = 0; i < expq.size(); i++) begin
        if (expq[i].k == k) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0 && expq[idx].due == cyc) begin
        exp_v     = 1'b1;
        exp_d     = expq[idx].d;
        exp_pe    = expq[idx].pe;
        last_d[k] = exp_d;
        expq.delete(idx);
      end
      check("ready", k, 32'(rdy[k]), 32'(fill_cnt[k] >= dep[k]));
      check("dout_valid", k, 32'(dv[k]), 32'(exp_v));
      check("dout", k, dout[k], exp_d);
      check("par_err", k, 32'(pe[k]), 32'(exp_pe));
    end
  endtask

  task automatic tick(input logic e, input logic w, input logic [3:0] b, input logic [4:0] a,
                      input logic [31:0] d);
    en   = e;
    we   = w;
    be   = b;
    addr = a;
    di   = d;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic rnd_tick();
    tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 5'($urandom), $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
  endtask

  initial begin
    dep[0] = 32; lat[0] = 1; mode[0] = NO_CHG;
    dep[1] = 32; lat[1] = 2; mode[1] = WR_FIRST;
    dep[2] = 20; lat[2] = 1; mode[2] = RD_FIRST;
    cyc    = 0;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    en = 1'b0; we = 1'b0; be = 4'h0; addr = 5'd0; di = 32'h0;
    @(negedge clk);

    // Reset with requests present, then fill with random requests that must be ignored.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 4'hF, 5'd3, 32'hDEADBEEF);
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) rnd_tick();

    // Every address after fill (u2 range 20..31 returns zero).
    for (int a = 0; a < 32; a++) tick(1'b1, 1'b0, 4'h0, 5'(a), 32'h0);
    idle(2);

    // Byte-enable merge.
    tick(1'b1, 1'b1, 4'hF, 5'd5, 32'hAABBCCDD);
    tick(1'b1, 1'b1, 4'h5, 5'd5, 32'h11223344);
    tick(1'b1, 1'b0, 4'h0, 5'd5, 32'h0);
    check("be_merge_rd5", 0, dout[0], 32'hAA22CC44);
    tick(1'b1, 1'b1, 4'h0, 5'd5, 32'hFFFFFFFF);
    tick(1'b1, 1'b0, 4'h0, 5'd5, 32'h0);
    idle(2);

    // Read-during-write modes.
    tick(1'b1, 1'b1, 4'hF, 5'd7, 32'h12345678);
    idle(2);
    tick(1'b1, 1'b1, 4'hF, 5'd7, 32'hFFFFFFFF);
    check("nochg_valid", 0, 32'(dv[0]), 32'h0);
    check("rdfirst_dout", 2, dout[2], 32'h12345678);
    idle(1);
    check("wrfirst_dout", 1, dout[1], 32'hFFFFFFFF);
    idle(2);

    // Back-to-back reads.
    tick(1'b1, 1'b1, 4'hF, 5'd1, 32'h01010101);
    tick(1'b1, 1'b1, 4'hF, 5'd2, 32'h02020202);
    tick(1'b1, 1'b1, 4'hF, 5'd3, 32'h03030303);
    tick(1'b1, 1'b0, 4'h0, 5'd1, 32'h0);
    tick(1'b1, 1'b0, 4'h0, 5'd2, 32'h0);
    tick(1'b1, 1'b0, 4'h0, 5'd3, 32'h0);
    idle(3);

    // Out-of-range traffic for the 20-word instance.
    tick(1'b1, 1'b1, 4'hF, 5'd25, 32'hCAFEF00D);
    tick(1'b1, 1'b0, 4'h0, 5'd25, 32'h0);
    idle(2);

    // Corrupt one stored bit behind the parity.
    tick(1'b1, 1'b1, 4'hF, 5'd9, 32'h5A5A5A5A);
    idle(2);
`ifdef SPRAM_PARITY_EN
    u0.mem_q[9][3] = ~u0.mem_q[9][3];
    mm[0][9][3]    = ~mm[0][9][3];
    bad[0][9][0]   = ~bad[0][9][0];
`endif
    tick(1'b1, 1'b0, 4'h0, 5'd9, 32'h0);
    check("par_rd9_valid", 0, 32'(dv[0]), 32'h1);
    check("par_rd9_err", 0, 32'(pe[0]), 32'(PAR_ON));
    tick(1'b1, 1'b0, 4'h0, 5'd10, 32'h0);
    check("par_rd10_err", 0, 32'(pe[0]), 32'h0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 300; i++) rnd_tick();
    idle(3);

    // Reset with a read in flight, then reset again mid-fill.
    tick(1'b1, 1'b0, 4'h0, 5'd4, 32'h0);
    rst_n = 1'b0;
    tick(1'b1, 1'b0, 4'h0, 5'd4, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) rnd_tick();
    rst_n = 1'b0;
    tick(1'b1, 1'b1, 4'hF, 5'd0, 32'hFFFFFFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) rnd_tick();
    for (int a = 0; a < 32; a++) tick(1'b1, 1'b0, 4'h0, 5'(a), 32'h0);
    for (int i = 0; i < 100; i++) rnd_tick();
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
